// File: rtl/cfo_pkg.sv
// Shared types, constants and the rounding/saturation helper for the CFO estimator/derotator pair.
package cfo_pkg;
    localparam int PHASE_ACC_BITS = 32;
    localparam int IQ_WIDTH       = 16;
    localparam int LUT_ADDR_BITS  = 10;
    localparam int LUT_WIDTH      = 16;
    localparam int FINE_BITS      = 24;
    localparam int PROD_W         = IQ_WIDTH + LUT_WIDTH;
    localparam int SUM_W          = PROD_W + 1;
    localparam int SUM_X          = SUM_W + 1;
    localparam int QUARTER_OFFSET = 1 << (LUT_ADDR_BITS - 2);

    typedef logic signed [PHASE_ACC_BITS-1:0] phase_t;
    typedef logic signed [IQ_WIDTH-1:0]       iq_t;
    typedef logic signed [LUT_WIDTH-1:0]      lut_t;
    typedef logic signed [FINE_BITS-1:0]      fine_t;
    typedef logic signed [PROD_W-1:0]         prod_t;
    typedef logic signed [SUM_W-1:0]          sum_t;
    typedef logic [LUT_ADDR_BITS-1:0]         lut_addr_t;
    typedef enum logic {IDLE, ACTIVE} state_t;

    localparam logic signed [SUM_W:0] RND_HALF = SUM_X'(1 << (LUT_WIDTH - 2));
    localparam logic signed [SUM_W:0] SAT_HI   = SUM_X'((1 << (IQ_WIDTH - 1)) - 1);
    localparam logic signed [SUM_W:0] SAT_LO   = -SAT_HI;

    // Round half-up at bit LUT_WIDTH-1, then clamp symmetrically so -2^(W-1) never appears.
    function automatic iq_t sat_round(input sum_t s);
        logic signed [SUM_W:0] r;
        logic signed [SUM_W:0] q;
        r = {s[SUM_W-1], s} + RND_HALF;
        q = r >>> (LUT_WIDTH - 1);
        if (q > SAT_HI) begin
            q = SAT_HI;
        end else if (q < SAT_LO) begin
            q = SAT_LO;
        end
        return q[IQ_WIDTH-1:0];
    endfunction
endpackage

// File: rtl/cfo_derotator_if.sv
// Frequency-control and sample stream bundle between the CFO derotator and its neighbours.
interface cfo_derotator_if;
    import cfo_pkg::*;

    logic   freq_load;
    phase_t freq_word_in;
    fine_t  fine_word_in;
    logic   clr;
    logic   vld_in;
    iq_t    i_in;
    iq_t    q_in;
    logic   vld_out;
    iq_t    i_out;
    iq_t    q_out;
    phase_t freq_active;
    logic   locked;

    modport master (
        output freq_load, freq_word_in, fine_word_in, clr, vld_in, i_in, q_in,
        input  vld_out, i_out, q_out, freq_active, locked
    );
    modport slave (
        input  freq_load, freq_word_in, fine_word_in, clr, vld_in, i_in, q_in,
        output vld_out, i_out, q_out, freq_active, locked
    );
endinterface

// File: rtl/cfo_sincos_lut.sv
// Full-cycle sine ROM with two registered read ports (sin and cos), table built at elaboration.
module cfo_sincos_lut
    import cfo_pkg::*;
(
    input  logic      clk,
    input  lut_addr_t sin_addr_i,
    input  lut_addr_t cos_addr_i,
    output lut_t      sin_o,
    output lut_t      cos_o
);
    localparam int     DEPTH       = 1 << LUT_ADDR_BITS;
    localparam int     QW          = DEPTH / 4;
    localparam longint AMP         = longint'((1 << (LUT_WIDTH - 1)) - 1);
    localparam longint HALF_PI_Q30 = 64'sd1686629713;

    // Quarter-wave Taylor series in Q30, mirrored into the other three quadrants.
    function automatic lut_t sin_entry(input int k);
        int     quad, idx, j;
        longint x, x2, term, acc, v;
        quad = k / QW;
        idx  = k % QW;
        j    = (quad % 2 == 1) ? QW - idx : idx;
        x    = (longint'(j) * HALF_PI_Q30) / longint'(QW);
        x2   = (x * x) >>> 30;
        term = x;
        acc  = x;
        for (int n = 1; n <= 5; n++) begin
            term = -((term * x2) >>> 30) / longint'(2 * n * (2 * n + 1));
            acc  = acc + term;
        end
        v = (acc * AMP + (longint'(1) <<< 29)) >>> 30;
        if (v > AMP) v = AMP;
        if (v < 0)   v = 0;
        if (quad >= 2) v = -v;
        return lut_t'(v);
    endfunction

    lut_t rom [DEPTH];

    for (genvar k = 0; k < DEPTH; k++) begin : g_rom
        localparam lut_t ROM_K = sin_entry(k);
        assign rom[k] = ROM_K;
    end

    always_ff @(posedge clk) begin
        sin_o <= rom[sin_addr_i];
        cos_o <= rom[cos_addr_i];
    end
endmodule

// File: rtl/cfo_derotator.sv
// Coarse-CFO derotator: phase accumulator NCO plus 5-register rotate pipeline (i,q)*exp(-j*phase).
// Optional CFO_DITHER_EN adds LFSR dither below the LUT address to spread truncation spurs.
module cfo_derotator
    import cfo_pkg::*;
(
    input logic            clk,
    input logic            rst,
    cfo_derotator_if.slave bus
);
    localparam int SHIFT = PHASE_ACC_BITS - LUT_ADDR_BITS;

    state_t    state_q, state_d;
    phase_t    freq_q, freq_d;
    phase_t    phase_q, phase_d;
    phase_t    dith;
    lut_addr_t addr_d;

    logic      vld_p0, vld_p1, vld_p2, vld_p3, vld_out_q;
    iq_t       i_p0, q_p0, i_p1, q_p1;
    lut_addr_t addr_p0;
    lut_t      sin_p1, cos_p1;
    prod_t     ic_p2, qs_p2, qc_p2, is_p2;
    sum_t      si_p3, sq_p3;
    iq_t       i_out_q, q_out_q;

    always_comb begin
        state_d = state_q;
        freq_d  = freq_q;
        phase_d = phase_q;
        if (bus.vld_in) begin
            phase_d = phase_q + freq_q + phase_t'(bus.fine_word_in);
        end
        case (state_q)
            IDLE: begin
                if (bus.freq_load) begin
                    state_d = ACTIVE;
                    freq_d  = bus.freq_word_in;
                end
            end
            ACTIVE: begin
                if (bus.freq_load) begin
                    freq_d = bus.freq_word_in;
                end
            end
            default: state_d = IDLE;
        endcase
        if (bus.clr) begin
            state_d = IDLE;
            freq_d  = '0;
            phase_d = '0;
        end
    end

`ifdef CFO_DITHER_EN
    localparam int          DITH_BITS = (SHIFT > 16) ? 16 : SHIFT;
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    logic [15:0] lfsr_q, lfsr_d;

    always_comb begin
        lfsr_d = lfsr_q;
        if (bus.vld_in) begin
            lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        end
        if (bus.clr) begin
            lfsr_d = LFSR_SEED;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) lfsr_q <= LFSR_SEED;
        else     lfsr_q <= lfsr_d;
    end

    assign dith = phase_t'(lfsr_q[15 -: DITH_BITS]) << (SHIFT - DITH_BITS);
`else
    assign dith = '0;
`endif

    // A sample taken on the clr edge already sees phase zero.
    assign addr_d = bus.clr ? lut_addr_t'(dith >> SHIFT)
                            : lut_addr_t'((phase_q + dith) >> SHIFT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            freq_q    <= '0;
            phase_q   <= '0;
            vld_p0    <= 1'b0;
            vld_p1    <= 1'b0;
            vld_p2    <= 1'b0;
            vld_p3    <= 1'b0;
            vld_out_q <= 1'b0;
            i_out_q   <= '0;
            q_out_q   <= '0;
        end else begin
            state_q   <= state_d;
            freq_q    <= freq_d;
            phase_q   <= phase_d;
            vld_p0    <= bus.vld_in;
            vld_p1    <= vld_p0;
            vld_p2    <= vld_p1;
            vld_p3    <= vld_p2;
            vld_out_q <= vld_p3;
            // output stage: round and saturate
            if (vld_p3) begin
                i_out_q <= sat_round(si_p3);
                q_out_q <= sat_round(sq_p3);
            end
        end
    end

    // S1 sample+address, S2 LUT read, S3 multiply, S4 add
    always_ff @(posedge clk) begin
        i_p0    <= bus.i_in;
        q_p0    <= bus.q_in;
        addr_p0 <= addr_d;
        i_p1    <= i_p0;
        q_p1    <= q_p0;
        ic_p2   <= i_p1 * cos_p1;
        qs_p2   <= q_p1 * sin_p1;
        qc_p2   <= q_p1 * cos_p1;
        is_p2   <= i_p1 * sin_p1;
        si_p3   <= sum_t'(ic_p2) + sum_t'(qs_p2);
        sq_p3   <= sum_t'(qc_p2) - sum_t'(is_p2);
    end

    cfo_sincos_lut u_lut (
        .clk        (clk),
        .sin_addr_i (addr_p0),
        .cos_addr_i (addr_p0 + lut_addr_t'(QUARTER_OFFSET)),
        .sin_o      (sin_p1),
        .cos_o      (cos_p1)
    );

    assign bus.vld_out     = vld_out_q;
    assign bus.i_out       = i_out_q;
    assign bus.q_out       = q_out_q;
    assign bus.freq_active = freq_q;
    assign bus.locked      = (state_q == ACTIVE);
endmodule

// File: tb/tb_cfo_derotator.sv
// Directed bench for cfo_derotator: reset, latency, rotation, saturation, load/clr corner cases.
module tb_cfo_derotator;
    import cfo_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;
    iq_t  cap_i[$];
    iq_t  cap_q[$];

    cfo_derotator_if bus();

    cfo_derotator dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.vld_out === 1'b1) begin
            cap_i.push_back(bus.i_out);
            cap_q.push_back(bus.q_out);
        end
    end

    task automatic idle_inputs();
        bus.freq_load    = 1'b0;
        bus.freq_word_in = '0;
        bus.fine_word_in = '0;
        bus.clr          = 1'b0;
        bus.vld_in       = 1'b0;
        bus.i_in         = '0;
        bus.q_in         = '0;
    endtask

    // Called and returning at 1 time unit after a rising edge.
    task automatic send(input int i, input int q, input int n);
        for (int k = 0; k < n; k++) begin
            bus.vld_in = 1'b1;
            bus.i_in   = iq_t'(i);
            bus.q_in   = iq_t'(q);
            @(posedge clk);
            #1;
        end
        bus.vld_in = 1'b0;
    endtask

    task automatic pulse_load(input logic [31:0] w);
        bus.freq_load    = 1'b1;
        bus.freq_word_in = phase_t'(w);
        @(posedge clk);
        #1;
        bus.freq_load = 1'b0;
    endtask

    task automatic pulse_clr();
        bus.clr = 1'b1;
        @(posedge clk);
        #1;
        bus.clr = 1'b0;
    endtask

    task automatic wait_outputs(input int n, input string name);
        for (int c = 0; c < 20 && cap_i.size() < n; c++) @(negedge clk);
        total++;
        if (cap_i.size() < n) begin
            bad++;
            $display("FAIL %s_count: got %0d outputs, want %0d", name, cap_i.size(), n);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (bus.vld_out !== 1'b0 || bus.locked !== 1'b0) begin
            bad++;
            $display("FAIL reset_ctl: vld_out=%b locked=%b, want 0 0", bus.vld_out, bus.locked);
        end
        total++;
        if (bus.i_out !== 16'sd0 || bus.q_out !== 16'sd0 || bus.freq_active !== 32'sd0) begin
            bad++;
            $display("FAIL reset_data: i=%0d q=%0d freq=%h, want 0 0 0", bus.i_out, bus.q_out, bus.freq_active);
        end
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_no_load();
        bus.vld_in = 1'b1;
        bus.i_in   = 16'sd16384;
        bus.q_in   = 16'sd0;
        @(posedge clk);
        #1;
        bus.vld_in = 1'b0;
        for (int k = 0; k <= 4; k++) begin
            if (k > 0) @(posedge clk);
            @(negedge clk);
            total++;
            if (bus.vld_out !== (k == 4)) begin
                bad++;
                $display("FAIL t1_latency[%0d]: vld_out=%b want %b", k, bus.vld_out, (k == 4));
            end
        end
        total++;
        if (bus.i_out !== 16'sd16384 || bus.q_out !== 16'sd0) begin
            bad++;
            $display("FAIL t1_value: got (%0d,%0d) want (16384,0)", bus.i_out, bus.q_out);
        end
        @(posedge clk);
        #1;
        total++;
        if (bus.vld_out !== 1'b0 || bus.i_out !== 16'sd16384) begin
            bad++;
            $display("FAIL t1_hold: vld_out=%b i=%0d want 0 16384", bus.vld_out, bus.i_out);
        end
        total++;
        if (bus.locked !== 1'b0 || bus.freq_active !== 32'sd0) begin
            bad++;
            $display("FAIL t1_idle: locked=%b freq=%h want 0 0", bus.locked, bus.freq_active);
        end
    endtask

    task automatic test_rotation();
        int ei[4] = '{16384, 0, -16384, 0};
        int eq[4] = '{0, -16384, 0, 16384};
        pulse_load(32'h4000_0000);
        total++;
        if (bus.locked !== 1'b1 || bus.freq_active !== 32'sh4000_0000) begin
            bad++;
            $display("FAIL t2_load: locked=%b freq=%h want 1 40000000", bus.locked, bus.freq_active);
        end
        cap_i.delete();
        cap_q.delete();
        send(16384, 0, 4);
        wait_outputs(4, "t2");
        for (int k = 0; k < 4; k++) begin
            int ai, aq;
            ai = (k < cap_i.size()) ? int'(cap_i[k]) : 99999;
            aq = (k < cap_q.size()) ? int'(cap_q[k]) : 99999;
            total++;
            if (ai - ei[k] > 1 || ei[k] - ai > 1 || aq - eq[k] > 1 || eq[k] - aq > 1) begin
                bad++;
                $display("FAIL t2_rot[%0d]: got (%0d,%0d) want (%0d,%0d) +/-1", k, ai, aq, ei[k], eq[k]);
            end
        end
    endtask

    task automatic test_saturation();
        int ai, aq;
        pulse_clr();
        pulse_load(32'h2000_0000);
        cap_i.delete();
        cap_q.delete();
        send(-32768, -32768, 2);
        wait_outputs(2, "t3");
        ai = (cap_i.size() > 0) ? int'(cap_i[0]) : 99999;
        aq = (cap_q.size() > 0) ? int'(cap_q[0]) : 99999;
        total++;
        if (ai != -32767 || aq != -32767) begin
            bad++;
            $display("FAIL t3_phase0: got (%0d,%0d) want (-32767,-32767)", ai, aq);
        end
        ai = (cap_i.size() > 1) ? int'(cap_i[1]) : 99999;
        aq = (cap_q.size() > 1) ? int'(cap_q[1]) : 99999;
        total++;
        if (ai != -32767 || aq > 1 || aq < -1) begin
            bad++;
            $display("FAIL t3_sat45: got (%0d,%0d) want (-32767,0+/-1)", ai, aq);
        end
    endtask

    task automatic test_load_same_cycle();
        int ei[3] = '{16384, 16384, 0};
        int eq[3] = '{0, 0, -16384};
        pulse_clr();
        cap_i.delete();
        cap_q.delete();
        bus.freq_load    = 1'b1;
        bus.freq_word_in = 32'sh4000_0000;
        bus.vld_in       = 1'b1;
        bus.i_in         = 16'sd16384;
        bus.q_in         = 16'sd0;
        @(posedge clk);
        #1;
        bus.freq_load = 1'b0;
        send(16384, 0, 2);
        wait_outputs(3, "t4");
        for (int k = 0; k < 3; k++) begin
            int ai, aq;
            ai = (k < cap_i.size()) ? int'(cap_i[k]) : 99999;
            aq = (k < cap_q.size()) ? int'(cap_q[k]) : 99999;
            total++;
            if (ai - ei[k] > 1 || ei[k] - ai > 1 || aq - eq[k] > 1 || eq[k] - aq > 1) begin
                bad++;
                $display("FAIL t4_same_cycle[%0d]: got (%0d,%0d) want (%0d,%0d) +/-1", k, ai, aq, ei[k], eq[k]);
            end
        end
    endtask

    task automatic test_clr_and_load();
        bus.clr          = 1'b1;
        bus.freq_load    = 1'b1;
        bus.freq_word_in = 32'sh1234_5678;
        @(posedge clk);
        #1;
        bus.clr       = 1'b0;
        bus.freq_load = 1'b0;
        total++;
        if (bus.locked !== 1'b0 || bus.freq_active !== 32'sd0) begin
            bad++;
            $display("FAIL t5_clr_wins: locked=%b freq=%h want 0 0", bus.locked, bus.freq_active);
        end
        cap_i.delete();
        cap_q.delete();
        send(16384, 0, 2);
        wait_outputs(2, "t5");
        for (int k = 0; k < 2; k++) begin
            int ai, aq;
            ai = (k < cap_i.size()) ? int'(cap_i[k]) : 99999;
            aq = (k < cap_q.size()) ? int'(cap_q[k]) : 99999;
            total++;
            if (ai != 16384 || aq != 0) begin
                bad++;
                $display("FAIL t5_unrotated[%0d]: got (%0d,%0d) want (16384,0)", k, ai, aq);
            end
        end
    endtask

    task automatic test_async_reset();
        int spurious;
        pulse_load(32'h4000_0000);
        send(16384, 0, 4);
        @(posedge clk);
        #2;
        total++;
        if (bus.vld_out !== 1'b1) begin
            bad++;
            $display("FAIL t6_first_out: vld_out=%b want 1", bus.vld_out);
        end
        rst = 1'b1;
        #1;
        total++;
        if (bus.vld_out !== 1'b0 || bus.i_out !== 16'sd0 || bus.q_out !== 16'sd0) begin
            bad++;
            $display("FAIL t6_async_clear: vld=%b i=%0d q=%0d want 0 0 0", bus.vld_out, bus.i_out, bus.q_out);
        end
        total++;
        if (bus.locked !== 1'b0 || bus.freq_active !== 32'sd0) begin
            bad++;
            $display("FAIL t6_async_ctl: locked=%b freq=%h want 0 0", bus.locked, bus.freq_active);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        spurious = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (bus.vld_out !== 1'b0) spurious++;
        end
        total++;
        if (spurious != 0) begin
            bad++;
            $display("FAIL t6_no_spurious: got %0d vld_out cycles want 0", spurious);
        end
    endtask

    initial begin
        test_reset();
        test_no_load();
        test_rotation();
        test_saturation();
        test_load_same_cycle();
        test_clr_and_load();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
